// File: rtl/mem_data_handler.sv
// Memory data handler: load extract/extend and store path with read-modify-write for sub-word stores.
// All outputs registered; one request at a time, start sampled only in IDLE.
module mem_data_handler #(
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE, ERR} state_t;

  localparam logic [2:0] RL = 3'(READ_LATENCY);

  state_t      state;
  logic        op_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic [2:0]  cnt;
  logic        misaligned;

  always_comb begin
    misaligned = (size == 2'b11) ||
                 (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Only sub-word stores reach the merge; word stores bypass the read.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[{lane, 3'b000} +: 8] = d[7:0];
    else             r[{lane[1], 4'b0000} +: 16] = d[15:0];
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      op_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      addr_q       <= '0;
      store_data_q <= '0;
      cnt          <= '0;
      load_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      mem_addr     <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q         <= op;
            size_q       <= size;
            sign_q       <= sign;
            addr_q       <= addr;
            store_data_q <= store_data;
            busy         <= 1'b1;
            mem_addr     <= {2'b00, addr[31:2]};
            if (misaligned) begin
              state <= ERR;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (op && size == 2'b10) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= store_data;
            end else begin
              state  <= RD;
              mem_re <= 1'b1;
            end
          end
        end
        RD: begin
          state <= RD_WAIT;
          cnt   <= 3'd1;
        end
        // cnt reaches RL in the cycle where mem_rdata is valid.
        RD_WAIT: begin
          if (cnt == RL) begin
            cnt <= '0;
            if (op_q) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= merge(mem_rdata, store_data_q, size_q, addr_q[1:0]);
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              load_data <= extract(mem_rdata, size_q, addr_q[1:0], sign_q);
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE, ERR: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_handler.sv
// Directed bench for mem_data_handler with a latency-accurate word RAM model.
module tb_mem_data_handler;
  localparam int RL = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        busy, done, error, mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem  [0:255];
  logic [31:0] pipe [0:7];
  logic [9:0]  re_m, we_m, done_m, err_m, busy_m;
  logic [31:0] ld_a [0:9];
  logic [31:0] maddr_a [0:9];
  logic [31:0] wdata_a [0:9];

  mem_data_handler #(.READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .size(size), .sign(sign),
    .addr(addr), .store_data(store_data), .load_data(load_data), .busy(busy),
    .done(done), .error(error), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Read data is only valid RL cycles after mem_re; garbage otherwise.
  always @(posedge clock) begin
    pipe[0] <= mem_re ? mem[mem_addr[7:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    if (!reset) begin
      mem[8'h70] <= 32'h8899_AABB;
      mem[8'h71] <= 32'h0000_0000;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic o, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] sd, input logic [9:0] pulse);
    @(negedge clock);
    op = o; size = sz; sign = sg; addr = a; store_data = sd; start = 1'b1;
    re_m = '0; we_m = '0; done_m = '0; err_m = '0; busy_m = '0;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      re_m[c] = mem_re; we_m[c] = mem_we; done_m[c] = done; err_m[c] = error; busy_m[c] = busy;
      ld_a[c] = load_data; maddr_a[c] = mem_addr; wdata_a[c] = mem_wdata;
      start = pulse[c];
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_err", {30'b0, done, error}, 0);
    chk("rst_re_we", {30'b0, mem_re, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_load_data", load_data, 0);
    @(negedge clock);
    reset = 1'b1;

    run(1'b0, 2'b10, 1'b0, 32'h1C0, 0, 0);
    chk("wl_re", 32'(re_m), 32'h002);
    chk("wl_we", 32'(we_m), 0);
    chk("wl_done", 32'(done_m), 32'h010);
    chk("wl_err", 32'(err_m), 0);
    chk("wl_busy", 32'(busy_m), 32'h01E);
    chk("wl_maddr1", maddr_a[1], 32'h70);
    chk("wl_maddr4", maddr_a[4], 32'h70);
    chk("wl_maddr_idle", maddr_a[6], 0);
    chk("wl_ld_before", ld_a[3], 0);
    chk("wl_ld", ld_a[4], 32'h8899_AABB);

    run(1'b0, 2'b00, 1'b1, 32'h1C3, 0, 0);
    chk("bl3_s", ld_a[4], 32'hFFFF_FF88);
    chk("bl3_done", 32'(done_m), 32'h010);
    run(1'b0, 2'b00, 1'b0, 32'h1C3, 0, 0);
    chk("bl3_z", ld_a[4], 32'h0000_0088);
    run(1'b0, 2'b00, 1'b1, 32'h1C0, 0, 0);
    chk("bl0_s", ld_a[4], 32'hFFFF_FFBB);
    run(1'b0, 2'b01, 1'b1, 32'h1C2, 0, 0);
    chk("hl2_s", ld_a[4], 32'hFFFF_8899);
    run(1'b0, 2'b01, 1'b1, 32'h1C0, 0, 0);
    chk("hl0_s", ld_a[4], 32'hFFFF_AABB);

    run(1'b1, 2'b00, 1'b0, 32'h1C1, 32'h1234_56CC, 0);
    chk("bs_re", 32'(re_m), 32'h002);
    chk("bs_we", 32'(we_m), 32'h010);
    chk("bs_wdata", wdata_a[4], 32'h8899_CCBB);
    chk("bs_wdata_idle", wdata_a[3], 0);
    chk("bs_maddr", maddr_a[4], 32'h70);
    chk("bs_done", 32'(done_m), 32'h020);
    chk("bs_busy", 32'(busy_m), 32'h03E);
    chk("bs_ld_kept", ld_a[5], 32'hFFFF_AABB);
    run(1'b0, 2'b10, 1'b0, 32'h1C0, 0, 0);
    chk("bs_readback", ld_a[4], 32'h8899_CCBB);

    run(1'b1, 2'b10, 1'b0, 32'h1C4, 32'hCAFE_F00D, 0);
    chk("ws_re", 32'(re_m), 0);
    chk("ws_we", 32'(we_m), 32'h002);
    chk("ws_wdata", wdata_a[1], 32'hCAFE_F00D);
    chk("ws_maddr", maddr_a[1], 32'h71);
    chk("ws_done", 32'(done_m), 32'h004);
    run(1'b1, 2'b01, 1'b0, 32'h1C6, 32'h5555_BEEF, 0);
    chk("hs_we", 32'(we_m), 32'h010);
    chk("hs_wdata", wdata_a[4], 32'hBEEF_F00D);
    chk("hs_done", 32'(done_m), 32'h020);
    run(1'b0, 2'b10, 1'b1, 32'h1C4, 0, 0);
    chk("hs_readback", ld_a[4], 32'hBEEF_F00D);

    run(1'b0, 2'b01, 1'b1, 32'h1C1, 0, 0);
    chk("mis_done", 32'(done_m), 32'h002);
    chk("mis_err", 32'(err_m), 32'h002);
    chk("mis_rewe", 32'(re_m | we_m), 0);
    chk("mis_busy", 32'(busy_m), 32'h002);
    chk("mis_ld", ld_a[3], 32'hBEEF_F00D);
    run(1'b0, 2'b11, 1'b0, 32'h1C0, 0, 0);
    chk("ill_done_err", 32'(done_m & err_m), 32'h002);
    chk("ill_rewe", 32'(re_m | we_m), 0);
    run(1'b1, 2'b10, 1'b0, 32'h1C2, 32'h1111_1111, 0);
    chk("misw_err", 32'(err_m), 32'h002);
    chk("misw_we", 32'(we_m), 0);

    run(1'b0, 2'b10, 1'b0, 32'h1C0, 0, 10'b00_0001_0100);
    chk("haz_re", 32'(re_m), 32'h002);
    chk("haz_we", 32'(we_m), 0);
    chk("haz_done", 32'(done_m), 32'h010);
    chk("haz_ld", ld_a[4], 32'h8899_CCBB);

    @(negedge clock);
    op = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h1C0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mrst_busy_re", {30'b0, busy, mem_re}, 0);
    chk("mrst_mem_addr", mem_addr, 0);
    chk("mrst_load_data", load_data, 0);
    @(negedge clock);
    reset = 1'b1;
    done_m = '0; busy_m = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      done_m[c] = done; busy_m[c] = busy;
    end
    chk("mrst_no_done", 32'(done_m | busy_m), 0);
    run(1'b0, 2'b10, 1'b0, 32'h1C0, 0, 0);
    chk("post_rst_done", 32'(done_m), 32'h010);
    chk("post_rst_ld", ld_a[4], 32'h8899_AABB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_data_handler.md
Name: mem_data_handler

Overview:
Memory Data Handler (MDH) for the ARMAria core. It is the memory-side counterpart of the register bank's MemOut/MemIn pair.
- Store path: takes store data (register bank MemOut) and writes it to word-organised data memory.
- Load path: reads memory and returns extracted, extended load data (register bank MemIn).
- Byte/halfword stores use a multi-cycle read-modify-write sequence because memory has no byte enables.
- Sits between the control unit, the register bank and the synchronous data RAM.

Parameters:
READ_LATENCY, 2, cycles from the mem_re cycle to the cycle in which mem_rdata is valid (legal range 1..7).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request strobe, sampled only in IDLE
op  in  1  0 = load, 1 = store
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  32  byte address
store_data  in  32  data from register bank MemOut
load_data  out  32  extended load result, to register bank MemIn
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
error  out  1  valid with done: misaligned or illegal size
mem_addr  out  32  word address = {2'b00, addr_q[31:2]}
mem_re  out  1  memory read strobe, one cycle
mem_we  out  1  memory write strobe, one cycle
mem_wdata  out  32  write data
mem_rdata  in  32  read data

Behaviour:
- Clock/reset: one clock, `clock`. `reset` is asynchronous and active-low.
  - While reset=0: all outputs 0 (including load_data), FSM in IDLE, latency counter 0.
  - Reset mid-operation aborts the operation; mem_re/mem_we drop immediately, and no done is issued.
- Capture and start:
  - On the rising edge where start=1 in IDLE (call it E0), latch op, size, sign, addr, store_data into _q registers.
  - start is ignored in every other state, including the done cycle.
- Cycle numbering: cycle n = the cycle after edge En.
- busy is high from cycle 1 through the done cycle inclusive.
- Alignment check (at E0):
  - Halfword with addr[0]=1, word with addr[1:0]!=0, or size=11 -> state ERR.
  - ERR: done=1 and error=1 in cycle 1, no mem_re/mem_we, load_data unchanged.
- FSM states: IDLE, RD, RD_WAIT, WR, DONE, ERR.
- Load:
  - RD (cycle 1): mem_re=1.
  - RD_WAIT: count READ_LATENCY cycles; mem_rdata is sampled at the end of cycle 1+READ_LATENCY.
  - DONE in cycle 2+READ_LATENCY: done=1, load_data updated in that same cycle.
- Word store: WR in cycle 1 (mem_we=1, mem_wdata=store_data_q); DONE in cycle 2.
- Sub-word store:
  - RD in cycle 1; capture the old word as for a load.
  - WR in cycle 2+READ_LATENCY with the merged word; DONE in cycle 3+READ_LATENCY.
- Lane select (little-endian):
  - Byte lane = addr_q[1:0], bits [8k+7:8k].
  - Halfword lane = addr_q[1], bits [16h+15:16h].
- Load extension: sign=1 replicates the top bit of the extracted byte/half; sign=0 zero-fills. Word loads ignore sign.
- Store merge:
  - Byte: replace the selected byte with store_data_q[7:0].
  - Half: replace the selected half with store_data_q[15:0].
  - Other lanes keep the read value.
- Output hold rules:
  - load_data holds its value until the next successful load; stores and errors never change it.
  - mem_addr is held for the whole operation and is 0 in IDLE.
  - mem_wdata is 0 whenever mem_we=0.
- Sequencing: done and error are single-cycle pulses; FSM returns to IDLE after DONE/ERR. A new start is accepted on the edge ending the done cycle +1, i.e. once busy=0.
- Invariant: mem_re and mem_we are never high in the same cycle.

Test Plan:
- Word load (READ_LATENCY=2), mem[0x70]=0x8899AABB, start with addr=0x1C0:
  - required: mem_addr=0x70, mem_re in cycle 1 only;
  - done in cycle 4 with load_data=0x8899AABB, error=0.
- Byte load, same word, addr=0x1C3:
  - sign=1 -> load_data=0xFFFFFF88;
  - sign=0 -> 0x00000088;
  - addr=0x1C0, sign=1 -> 0xFFFFFFBB.
- Halfword load, addr=0x1C2, sign=1 -> 0xFFFF8899. Halfword load, addr=0x1C0, sign=1 -> 0xFFFFAABB.
- Byte store, store_data=0x123456CC, addr=0x1C1, mem word 0x8899AABB:
  - required: mem_re in cycle 1; mem_we in cycle 4 with mem_wdata=0x8899CCBB;
  - done in cycle 5; load_data unchanged.
- Misaligned and illegal requests:
  - halfword load at 0x1C1 -> done=1, error=1 in cycle 1, no mem_re/mem_we;
  - size=11 -> same.
- Control hazards:
  - start pulsed during busy -> ignored, exactly one done;
  - reset=0 in cycle 2 of a load -> all outputs 0 immediately, no done after release;
  - next load after release completes normally.
